// File: rtl/case_4_sdiv_26s_12s_14_seq_if.sv
// Start/ready/done handshake bundle for the sequential signed divider.
// The master side issues operands; the slave side (the divider) returns results.
interface case_4_sdiv_26s_12s_14_seq_if #(
    parameter int din0_WIDTH = 26,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 14
) ();
    logic                         start;
    logic signed [din0_WIDTH-1:0] din0;
    logic signed [din1_WIDTH-1:0] din1;
    logic                         ready;
    logic                         done;
    logic signed [dout_WIDTH-1:0] dout;
    logic signed [din1_WIDTH-1:0] rem;
    logic                         div_by_zero;

    modport master (
        output start, din0, din1,
        input  ready, done, dout, rem, div_by_zero
    );

    modport slave (
        input  start, din0, din1,
        output ready, done, dout, rem, div_by_zero
    );
endinterface

// File: rtl/case_4_sdiv_26s_12s_14_seq.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, C truncation semantics via a final sign fix.
module case_4_sdiv_26s_12s_14_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 26,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 14
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    case_4_sdiv_26s_12s_14_seq_if.slave bus
);
    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(din0_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                       state_q, state_d;
    logic [din0_WIDTH-1:0]        q_q, q_d;
    logic [din1_WIDTH-1:0]        dvs_q, dvs_d;
    logic [din1_WIDTH-1:0]        prem_q, prem_d;
    logic [din1_WIDTH-1:0]        rdz_q, rdz_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         sq_q, sq_d;
    logic                         sr_q, sr_d;
    logic                         dz_q, dz_d;
    logic signed [dout_WIDTH-1:0] dout_q, dout_d;
    logic signed [din1_WIDTH-1:0] rem_q, rem_d;
    logic                         dbz_q, dbz_d;
    logic [din1_WIDTH:0]          shifted;
    logic [din1_WIDTH:0]          trial;
    logic                         unused_id;

    // Magnitudes are read as unsigned, so the most negative value maps to 2^(W-1) exactly.
    function automatic logic [din0_WIDTH-1:0] abs_din0(input logic signed [din0_WIDTH-1:0] v);
        return v[din0_WIDTH-1] ? unsigned'(-v) : unsigned'(v);
    endfunction

    function automatic logic [din1_WIDTH-1:0] abs_din1(input logic signed [din1_WIDTH-1:0] v);
        return v[din1_WIDTH-1] ? unsigned'(-v) : unsigned'(v);
    endfunction

    function automatic logic [dout_WIDTH-1:0] fix_quot(input logic neg, input logic [din0_WIDTH-1:0] mag);
        return dout_WIDTH'(neg ? -mag : mag);
    endfunction

    function automatic logic [din1_WIDTH-1:0] fix_rem(input logic neg, input logic [din1_WIDTH-1:0] mag);
        return neg ? -mag : mag;
    endfunction

    assign unused_id = (ID != 0);

    assign shifted = {prem_q, q_q[din0_WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        rdz_d   = rdz_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d     = abs_din0(bus.din0);
                    dvs_d   = abs_din1(bus.din1);
                    sq_d    = bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
                    sr_d    = bus.din0[din0_WIDTH-1];
                    dz_d    = (bus.din1 == '0);
                    rdz_d   = bus.din0[din1_WIDTH-1:0];
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Restoring step: keep the trial difference only when it did not borrow.
                q_d    = {q_q[din0_WIDTH-2:0], ~trial[din1_WIDTH]};
                prem_d = trial[din1_WIDTH] ? shifted[din1_WIDTH-1:0] : trial[din1_WIDTH-1:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    dbz_d   = dz_q;
                    dout_d  = dz_q ? '1    : fix_quot(sq_q, q_d);
                    rem_d   = dz_q ? rdz_q : fix_rem(sr_q, prem_d);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            rdz_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            rdz_q   <= rdz_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.dout        = dout_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_case_4_sdiv_26s_12s_14_seq.sv
// Bench for the sequential signed divider: directed cases, handshake timing,
// mid-operation reset and randomized operands against a C-semantics model.
module tb_case_4_sdiv_26s_12s_14_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    case_4_sdiv_26s_12s_14_seq_if bus ();

    case_4_sdiv_26s_12s_14_seq dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain truncating integer division and modulo.
    function automatic void ref_div(input logic signed [25:0] a, input logic signed [11:0] b,
                                    output logic [13:0] q, output logic [11:0] r, output logic dz);
        longint la, lb, lq, lr;
        la = a;
        lb = b;
        if (lb == 0) begin
            q  = '1;
            r  = a[11:0];
            dz = 1'b1;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q  = lq[13:0];
            r  = lr[11:0];
            dz = 1'b0;
        end
    endfunction

    task automatic run_op(input logic signed [25:0] a, input logic signed [11:0] b,
                          input logic [13:0] eq, input logic [11:0] er, input logic edz,
                          input bit poke);
        int n;
        bit seen;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, bus.ready}, 32'd1);
        bus.start = 1'b1;
        bus.din0  = a;
        bus.din1  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.din0  = 26'($urandom);
        bus.din1  = 12'($urandom);
        check("ready_low", {31'b0, bus.ready}, 32'd0);
        n    = 1;
        seen = bus.done;
        while (!seen && n < 60) begin
            if (poke && n == 8) bus.start = 1'b1;
            if (poke && n == 9) bus.start = 1'b0;
            @(negedge clk);
            n++;
            seen = bus.done;
        end
        check("latency", n, 32'd27);
        check("dout", {18'b0, bus.dout}, {18'b0, eq});
        check("rem", {20'b0, bus.rem}, {20'b0, er});
        check("dbz", {31'b0, bus.div_by_zero}, {31'b0, edz});
        @(negedge clk);
        check("done_pulse", {31'b0, bus.done}, 32'd0);
        check("ready_back", {31'b0, bus.ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] eq;
        logic [11:0] er;
        logic        edz;
        logic signed [25:0] a;
        logic signed [11:0] b;
        int acc[3];
        int na, nd, sel;
        bit drop;

        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_dout", {18'b0, bus.dout}, 32'd0);
        check("rst_rem", {20'b0, bus.rem}, 32'd0);
        check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run_op(26'sd1000, 12'sd7, 14'd142, 12'd6, 1'b0, 1'b0);
        run_op(-26'sd1000, 12'sd7, 14'h3F72, 12'hFFA, 1'b0, 1'b0);
        run_op(26'sd1000, -12'sd7, 14'h3F72, 12'd6, 1'b0, 1'b1);
        run_op(-26'sd1000, -12'sd7, 14'd142, 12'hFFA, 1'b0, 1'b0);
        run_op(26'h2000000, 12'hFFF, 14'd0, 12'd0, 1'b0, 1'b0);
        run_op(26'sd30000, 12'sd1, 14'd13616, 12'd0, 1'b0, 1'b0);
        run_op(26'sd5, 12'h800, 14'd0, 12'd5, 1'b0, 1'b1);
        run_op(26'sd12345, 12'sd0, 14'h3FFF, 12'h039, 1'b1, 1'b0);
        run_op(26'sd8, 12'sd2, 14'd4, 12'd0, 1'b0, 1'b0);

        // start held high across three back-to-back operations
        acc       = '{0, 0, 0};
        na        = 0;
        nd        = 0;
        drop      = 1'b0;
        bus.din0  = 26'sd1000;
        bus.din1  = 12'sd7;
        bus.start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (drop) bus.start = 1'b0;
            if (bus.done) begin
                nd++;
                check("tput_dout", {18'b0, bus.dout}, 32'd142);
            end
            if (bus.ready && bus.start) begin
                if (na < 3) acc[na] = i;
                na++;
                if (na == 3) drop = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("tput_accepts", na, 32'd3);
        check("tput_gap1", acc[1] - acc[0], 32'd28);
        check("tput_gap2", acc[2] - acc[1], 32'd28);
        check("tput_dones", nd, 32'd3);

        // reset in the middle of CALC
        sel = 0;
        while (!bus.ready && sel < 100) begin
            @(negedge clk);
            sel++;
        end
        bus.start = 1'b1;
        bus.din0  = 26'sd500000;
        bus.din1  = 12'sd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, bus.ready}, 32'd1);
        check("mid_rst_done", {31'b0, bus.done}, 32'd0);
        check("mid_rst_dout", {18'b0, bus.dout}, 32'd0);
        check("mid_rst_rem", {20'b0, bus.rem}, 32'd0);
        check("mid_rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        check("mid_rst_hold", {31'b0, bus.done}, 32'd0);
        rst_n = 1'b1;
        run_op(26'sd100, 12'sd9, 14'd11, 12'd1, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            a   = 26'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 12'sd0;
            else if (sel == 1) b = 12'h800;
            else if (sel == 2) b = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1, 15))
                                                               : -12'($urandom_range(1, 15));
            else               b = 12'($urandom);
            ref_div(a, b, eq, er, edz);
            run_op(a, b, eq, er, edz, (i % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
